// File: rtl/wave_measure_if.sv
// Square-wave measurement bus: the waveform under test going in, per-cycle
// high/low/period results plus a one-cycle valid pulse coming out.
interface wave_measure_if #(
    parameter int CNT_W = 16
);
    logic             wave_in;
    logic [CNT_W-1:0] high_len;
    logic [CNT_W-1:0] low_len;
    logic [CNT_W:0]   period;
    logic             valid;
    logic             sat;

    // measurement block: samples the wave, drives the results
    modport master (
        input  wave_in,
        output high_len, low_len, period, valid, sat
    );

    // source/logger side: drives the wave, consumes the results
    modport slave (
        output wave_in,
        input  high_len, low_len, period, valid, sat
    );
endinterface

// File: rtl/wave_measure.sv
// Measures high time, low time and period of each full cycle of an
// asynchronous square wave, in clk cycles, with saturating counters.
module wave_measure #(
    parameter int CNT_W = 16
) (
    input  logic           clk,
    input  logic           reset,
    wave_measure_if.master bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        WAIT_RISE = 2'd0,
        MEAS_HIGH = 2'd1,
        MEAS_LOW  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             s1, s2, s2_d;
    logic             rise, fall;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] lcnt_q, lcnt_d;
    logic             sat_acc_q, sat_acc_d;
    logic             report;

    // two-flop synchronizer plus one delay stage for edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            s2_d <= 1'b0;
        end else begin
            s1   <= bus.wave_in;
            s2   <= s1;
            s2_d <= s2;
        end
    end

    assign rise = s2 & ~s2_d;
    assign fall = ~s2 & s2_d;

    // next-state and counter update; counters hold at max and flag sat_acc
    always_comb begin
        state_d   = state_q;
        hcnt_d    = hcnt_q;
        lcnt_d    = lcnt_q;
        sat_acc_d = sat_acc_q;
        report    = 1'b0;
        case (state_q)
            WAIT_RISE: begin
                // partial cycle after reset is discarded: wait for a clean rise
                if (rise) begin
                    hcnt_d    = CNT_ONE;
                    sat_acc_d = 1'b0;
                    state_d   = MEAS_HIGH;
                end
            end
            MEAS_HIGH: begin
                if (fall) begin
                    lcnt_d  = CNT_ONE;
                    state_d = MEAS_LOW;
                end else if (hcnt_q == CNT_MAX) begin
                    sat_acc_d = 1'b1;
                end else begin
                    hcnt_d = hcnt_q + CNT_ONE;
                end
            end
            MEAS_LOW: begin
                if (rise) begin
                    // rise closes this cycle and opens the next high phase
                    report    = 1'b1;
                    hcnt_d    = CNT_ONE;
                    sat_acc_d = 1'b0;
                    state_d   = MEAS_HIGH;
                end else if (lcnt_q == CNT_MAX) begin
                    sat_acc_d = 1'b1;
                end else begin
                    lcnt_d = lcnt_q + CNT_ONE;
                end
            end
            default: state_d = WAIT_RISE;
        endcase
    end

    // FSM state and measurement counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= WAIT_RISE;
            hcnt_q    <= '0;
            lcnt_q    <= '0;
            sat_acc_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hcnt_q    <= hcnt_d;
            lcnt_q    <= lcnt_d;
            sat_acc_q <= sat_acc_d;
        end
    end

    // registered results; period is one bit wider so it never wraps
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.high_len <= '0;
            bus.low_len  <= '0;
            bus.period   <= '0;
            bus.sat      <= 1'b0;
            bus.valid    <= 1'b0;
        end else begin
            bus.valid <= report;
            if (report) begin
                bus.high_len <= hcnt_q;
                bus.low_len  <= lcnt_q;
                bus.period   <= {1'b0, hcnt_q} + {1'b0, lcnt_q};
                bus.sat      <= sat_acc_q;
            end
        end
    end
endmodule

// File: tb/tb_wave_measure.sv
// Scoreboard bench for wave_measure: two instances (wide and 4-bit counters)
// see the same wave; each driven cycle's expected result is queued at the
// rise that closes it and checked by per-instance monitors.
module tb_wave_measure;
    localparam int W_A = 16;
    localparam int W_B = 4;

    typedef struct {
        int unsigned h;
        int unsigned l;
        int unsigned due;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        wave;
    int unsigned cyc = 0;

    exp_t        qa[$];
    exp_t        qb[$];
    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned last_h[2], last_l[2], last_p[2], last_s[2];
    bit          have_prev = 1'b0;
    int unsigned prev_h, prev_l;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    wave_measure_if #(.CNT_W(W_A)) bus_a ();
    wave_measure_if #(.CNT_W(W_B)) bus_b ();
    assign bus_a.wave_in = wave;
    assign bus_b.wave_in = wave;

    wave_measure #(.CNT_W(W_A)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
    wave_measure #(.CNT_W(W_B)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

    task automatic chk(string name, longint unsigned act, longint unsigned exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int unsigned clip(int unsigned x, int w);
        int unsigned mx = (32'd1 << w) - 1;
        return (x > mx) ? mx : x;
    endfunction

    // reference: each level lasting N cycles counts N, clipped at 2^w-1;
    // sat whenever a level outlasted the counter
    task automatic score(int idx, int w, exp_t e, int unsigned hl, int unsigned ll,
                         int unsigned p, int unsigned s);
        int unsigned eh = clip(e.h, w);
        int unsigned el = clip(e.l, w);
        int unsigned es = (e.h > eh || e.l > el) ? 1 : 0;
        chk($sformatf("dut%0d_high_len", idx), hl, eh);
        chk($sformatf("dut%0d_low_len", idx), ll, el);
        chk($sformatf("dut%0d_period", idx), p, eh + el);
        chk($sformatf("dut%0d_sat", idx), s, es);
        chk($sformatf("dut%0d_valid_cycle", idx), cyc, e.due);
        last_h[idx] = eh;
        last_l[idx] = el;
        last_p[idx] = eh + el;
        last_s[idx] = es;
    endtask

    // monitor, wide instance
    always @(negedge clk) begin
        if (!reset) begin
            if (bus_a.valid) begin
                if (qa.size() == 0) chk("dut0_unexpected_valid", 1, 0);
                else begin
                    exp_t e;
                    e = qa.pop_front();
                    score(0, W_A, e, bus_a.high_len, bus_a.low_len, bus_a.period, bus_a.sat);
                end
            end else if (qa.size() > 0 && cyc > qa[0].due) begin
                chk("dut0_missing_valid", 0, 1);
                void'(qa.pop_front());
            end
        end
    end

    // monitor, 4-bit instance
    always @(negedge clk) begin
        if (!reset) begin
            if (bus_b.valid) begin
                if (qb.size() == 0) chk("dut1_unexpected_valid", 1, 0);
                else begin
                    exp_t e;
                    e = qb.pop_front();
                    score(1, W_B, e, bus_b.high_len, bus_b.low_len, bus_b.period, bus_b.sat);
                end
            end else if (qb.size() > 0 && cyc > qb[0].due) begin
                chk("dut1_missing_valid", 0, 1);
                void'(qb.pop_front());
            end
        end
    end

    // called at a negedge; drives h high then l low cycles, returns at a negedge.
    // The rise closes the previous cycle: its result is due three edges later.
    task automatic drive_seg(int unsigned h, int unsigned l);
        wave = 1'b1;
        if (have_prev) begin
            exp_t e;
            e.h   = prev_h;
            e.l   = prev_l;
            e.due = cyc + 3;
            qa.push_back(e);
            qb.push_back(e);
        end
        repeat (h) @(negedge clk);
        wave = 1'b0;
        repeat (l) @(negedge clk);
        prev_h    = h;
        prev_l    = l;
        have_prev = 1'b1;
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_a_high_len"}, bus_a.high_len, 0);
        chk({tag, "_a_low_len"},  bus_a.low_len,  0);
        chk({tag, "_a_period"},   bus_a.period,   0);
        chk({tag, "_a_valid"},    bus_a.valid,    0);
        chk({tag, "_a_sat"},      bus_a.sat,      0);
        chk({tag, "_b_high_len"}, bus_b.high_len, 0);
        chk({tag, "_b_period"},   bus_b.period,   0);
        chk({tag, "_b_sat"},      bus_b.sat,      0);
    endtask

    task automatic chk_hold(string tag);
        chk({tag, "_a_high_len"}, bus_a.high_len, last_h[0]);
        chk({tag, "_a_low_len"},  bus_a.low_len,  last_l[0]);
        chk({tag, "_a_period"},   bus_a.period,   last_p[0]);
        chk({tag, "_a_valid"},    bus_a.valid,    0);
        chk({tag, "_b_high_len"}, bus_b.high_len, last_h[1]);
        chk({tag, "_b_low_len"},  bus_b.low_len,  last_l[1]);
        chk({tag, "_b_period"},   bus_b.period,   last_p[1]);
        chk({tag, "_b_sat"},      bus_b.sat,      last_s[1]);
    endtask

    initial begin
        reset = 1'b1;
        wave  = 1'b0;
        #12;
        chk_zero("reset");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        repeat (5) drive_seg(20, 20);
        repeat (3) drive_seg(15, 15);
        repeat (2) drive_seg(3, 7);
        repeat (6) drive_seg(1, 1);
        drive_seg(20, 5);
        repeat (2) drive_seg(5, 5);
        repeat (2) drive_seg(10, 10);

        // abort a cycle in its low phase: async clear, measurement restarts
        wave = 1'b1;
        begin
            exp_t e;
            e.h = prev_h; e.l = prev_l; e.due = cyc + 3;
            qa.push_back(e);
            qb.push_back(e);
        end
        repeat (10) @(negedge clk);
        wave = 1'b0;
        repeat (6) @(negedge clk);
        #2 reset = 1'b1;
        #1 chk_zero("midreset");
        have_prev = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        repeat (3) drive_seg(10, 10);

        // stuck-high: nothing reported, outputs hold
        fork
            drive_seg(1000, 8);
            begin
                repeat (500) @(negedge clk);
                #1 chk_hold("hold");
            end
        join

        for (int i = 0; i < 40; i++) begin
            int unsigned h, l;
            h = ($urandom_range(0, 3) == 0) ? $urandom_range(14, 40) : $urandom_range(1, 16);
            l = ($urandom_range(0, 3) == 0) ? $urandom_range(14, 40) : $urandom_range(1, 16);
            drive_seg(h, l);
        end
        drive_seg(4, 4);

        for (int i = 0; i < 100 && (qa.size() != 0 || qb.size() != 0); i++) @(negedge clk);
        chk("drain_a", qa.size(), 0);
        chk("drain_b", qb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/wave_measure.md
# wave_measure

Square-wave measurement block: the receiving end of the lab's waveform generators. It samples one asynchronous single-bit waveform on the system clock and measures each full cycle of the waveform. For every cycle it reports the high time, the low time and the period, in clock cycles. It sits between a waveform source (stimulus block or external pin) and whatever logs or checks the waveform. Results are qualified by a one-cycle valid pulse.

## Interface
- CNT_W, 16: width of the high-time and low-time counters; counts saturate at 2^CNT_W-1.

- clk  input  1  system clock; everything is on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state and outputs.
- wave_in  input  1  waveform under measurement; asynchronous to clk.
- high_len  output  CNT_W  clock cycles wave was high in the last completed cycle.
- low_len  output  CNT_W  clock cycles wave was low in the last completed cycle.
- period  output  CNT_W+1  high_len + low_len; full width, never wraps.
- valid  output  1  one-cycle pulse when high_len/low_len/period update.
- sat  output  1  either counter saturated during the reported cycle; updates with valid.

## Operation
- Synchronizer: wave_in passes through two flops (s1, s2), then one more flop (s2_d) for edge detection.
  - rise = s2 & ~s2_d; fall = ~s2 & s2_d.
  - Synchronizer flops reset to 0.
- FSM states: WAIT_RISE (reset state), MEAS_HIGH, MEAS_LOW.
- WAIT_RISE:
  - Ignores everything until rise; any partial cycle after reset is discarded.
  - On rise: hcnt <= 1, go to MEAS_HIGH.
- MEAS_HIGH:
  - Each cycle without fall: hcnt <= hcnt+1.
  - On fall: lcnt <= 1, go to MEAS_LOW.
- MEAS_LOW:
  - Each cycle without rise: lcnt <= lcnt+1.
  - On rise:
    - high_len <= hcnt, low_len <= lcnt, period <= hcnt+lcnt, sat <= sat_acc, valid <= 1.
    - hcnt <= 1, clear sat_acc, go to MEAS_HIGH.
- Counting rule: a synchronized level lasting exactly N clock cycles yields a count of N. Minimum measurable high or low time is 1 cycle.
- Saturation:
  - hcnt/lcnt hold at 2^CNT_W-1 instead of wrapping; sat_acc is set when either counter would exceed the maximum.
  - State does not change on saturation; the cycle still completes on the next edge.
- period is computed at CNT_W+1 bits, so it is exact even when both counters are saturated.
- A static wave_in (stuck high or low) never produces valid. Outputs hold their last values indefinitely.
- Pulses on wave_in shorter than one clock period may be missed; this is accepted, not flagged.

## Timing
- Reset, asserted at any time including mid-measurement:
  - Asynchronously forces state = WAIT_RISE, hcnt = lcnt = 0, sat_acc = 0.
  - Forces high_len = low_len = period = 0, valid = 0, sat = 0.
- After reset release, the first valid needs a full rise, fall, rise sequence.
- Latency: wave_in rising edge sampled by s1 at clock edge k → rise seen in the cycle after edge k+1 → valid, high_len, low_len, period, sat registered at edge k+2. That is three clk edges from the first sampling edge.
- valid is high for exactly one clk cycle per measured waveform cycle. Outputs are stable between valid pulses.
- With a constant-rate input, consecutive valid pulses are exactly period clock cycles apart.
- All outputs are registered; there are no combinational paths from wave_in to any output.

## Test plan
- 20 high / 20 low, clk period 1 unit, 5 cycles → after the first discarded partial cycle, each valid gives high_len=20, low_len=20, period=40, sat=0; valid pulses 40 clocks apart.
- 15 high / 15 low → high_len=15, low_len=15, period=30. Then switch to 3 high / 7 low → next full cycle reports 3/7/10.
- Minimum waveform, 1 high / 1 low (wave_in toggled each clock, setup-safe) → high_len=1, low_len=1, period=2, valid every 2 clocks.
- CNT_W=4, 20 high / 5 low → high_len=15, low_len=5, period=20, sat=1. The following 5/5 cycle reports 5/5/10 with sat=0.
- Reset asserted in the middle of MEAS_LOW → all outputs 0 immediately, asynchronously. After release with a 10/10 wave, the first valid arrives only after a full rise, fall, rise sequence and reports 10/10/20.
- wave_in held high for 1000 clocks after one valid measurement → no further valid; outputs hold their previous values.
